sha2_compress_iter: RTL and testbench

- Iterative SHA-2 compression engine for SHA-256 and SHA-384/512/512-256.
- Accepts one chaining state (8 words) and one padded message block (16 words) per transaction.
- Runs 64 (SHA-256) or 80 (SHA-512 family) rounds, UNROLL rounds per clock, with an on-the-fly message schedule and feed-forward addition.
- Sits between the padding/block-feeder logic and the digest register file in the hash subsystem; reuses the existing per-round datapath formulation (T1/T2, Ch, Maj, Σ0/Σ1).

---
 rtl/sha2_compress_iter.sv | 238 +++++++++++++++++++++++
 tb/tb_sha2_compress_iter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_compress_iter.sv
// sha2_compress_iter: iterative SHA-256 / SHA-512-family compression engine.
// Runs UNROLL rounds per clock with a sliding 16-word message schedule and
// a feed-forward add in a dedicated FINAL cycle.
// Optional build macro SHA2_ZEROIZE_EN clears the digest, chaining, working and
// schedule registers on the output handshake.
module sha2_compress_iter #(
  parameter int unsigned UNROLL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode_in,
  input  logic [511:0]  state_in,
  input  logic [1023:0] block_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [511:0]  digest_out,
  output logic          busy
);

  localparam int unsigned W     = 64;
  localparam int unsigned NW    = 8;
  localparam int unsigned NM    = 16;
  localparam int unsigned CNT_W = 7;
  localparam logic [W-1:0] MASK32 = 64'h0000_0000_ffff_ffff;
  localparam logic [W-1:0] MASK64 = 64'hffff_ffff_ffff_ffff;

  // SHA-512 round constants; the upper 32 bits of the first 64 entries are the SHA-256 constants.
  localparam logic [W-1:0] K_TAB [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // Reject unsupported unroll factors at elaboration.
  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha2_compress_iter: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  function automatic logic [W-1:0] ror64(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [W-1:0] bsig0(input logic m, input logic [W-1:0] x);
    if (m) return ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
    return {32'h0, ror32(x[31:0], 2) ^ ror32(x[31:0], 13) ^ ror32(x[31:0], 22)};
  endfunction

  function automatic logic [W-1:0] bsig1(input logic m, input logic [W-1:0] x);
    if (m) return ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
    return {32'h0, ror32(x[31:0], 6) ^ ror32(x[31:0], 11) ^ ror32(x[31:0], 25)};
  endfunction

  function automatic logic [W-1:0] ssig0(input logic m, input logic [W-1:0] x);
    if (m) return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
    return {32'h0, ror32(x[31:0], 7) ^ ror32(x[31:0], 18) ^ (x[31:0] >> 3)};
  endfunction

  function automatic logic [W-1:0] ssig1(input logic m, input logic [W-1:0] x);
    if (m) return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
    return {32'h0, ror32(x[31:0], 17) ^ ror32(x[31:0], 19) ^ (x[31:0] >> 10)};
  endfunction

  state_e             state_q, state_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic               mode_q;
  logic [CNT_W-1:0]   t_q;
  logic [W-1:0]       h_q [NW];
  logic [W-1:0]       v_q [NW];
  logic [W-1:0]       w_q [NM];
  logic [W-1:0]       v_d [NW];
  logic [W-1:0]       w_d [NM];
  logic [511:0]       digest_q;

  logic               accept_c, step_c, final_c, hs_c;
  logic [CNT_W-1:0]   n_rounds_c;
  logic [W-1:0]       mask_c, in_mask_c;

  assign n_rounds_c = mode_q ? CNT_W'(80) : CNT_W'(64);
  assign mask_c     = mode_q ? MASK64 : MASK32;
  assign in_mask_c  = mode_in ? MASK64 : MASK32;

  // Next-state and per-state strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    final_c  = 1'b0;
    hs_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          accept_c = 1'b1;
          state_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        if (t_q == n_rounds_c) state_d = S_FINAL;
        else                   step_c  = 1'b1;
      end
      S_FINAL: begin
        final_c = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          hs_c    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // UNROLL chained rounds plus schedule window advance.
  always_comb begin
    logic [W-1:0]     t1, t2, wn, kk, chv, mjv;
    logic [CNT_W-1:0] idx;
    t1  = '0;
    t2  = '0;
    wn  = '0;
    kk  = '0;
    chv = '0;
    mjv = '0;
    idx = '0;
    v_d = v_q;
    w_d = w_q;
    for (int r = 0; r < int'(UNROLL); r++) begin
      idx = t_q + CNT_W'(r);
      if (idx > CNT_W'(79)) idx = '0;
      kk  = mode_q ? K_TAB[idx] : {32'h0, K_TAB[idx][63:32]};
      chv = (v_d[4] & v_d[5]) ^ (~v_d[4] & v_d[6]);
      mjv = (v_d[0] & v_d[1]) ^ (v_d[0] & v_d[2]) ^ (v_d[1] & v_d[2]);
      t1  = (v_d[7] + bsig1(mode_q, v_d[4]) + chv + kk + w_d[0]) & mask_c;
      t2  = (bsig0(mode_q, v_d[0]) + mjv) & mask_c;
      wn  = (ssig1(mode_q, w_d[14]) + w_d[9] + ssig0(mode_q, w_d[1]) + w_d[0]) & mask_c;
      v_d[7] = v_d[6];
      v_d[6] = v_d[5];
      v_d[5] = v_d[4];
      v_d[4] = (v_d[3] + t1) & mask_c;
      v_d[3] = v_d[2];
      v_d[2] = v_d[1];
      v_d[1] = v_d[0];
      v_d[0] = (t1 + t2) & mask_c;
      for (int j = 0; j < int'(NM) - 1; j++) w_d[j] = w_d[j+1];
      w_d[NM-1] = wn;
    end
  end

  // Datapath registers: load on accept, iterate in ROUND, feed-forward in FINAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 1'b0;
      t_q      <= '0;
      digest_q <= '0;
      for (int i = 0; i < int'(NW); i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      for (int j = 0; j < int'(NM); j++) w_q[j] <= '0;
    end else begin
      if (accept_c) begin
        mode_q <= mode_in;
        t_q    <= '0;
        for (int i = 0; i < int'(NW); i++) begin
          h_q[i] <= state_in[64*i +: 64] & in_mask_c;
          v_q[i] <= state_in[64*i +: 64] & in_mask_c;
        end
        for (int j = 0; j < int'(NM); j++) w_q[j] <= block_in[64*j +: 64] & in_mask_c;
      end
      if (step_c) begin
        v_q <= v_d;
        w_q <= w_d;
        t_q <= t_q + CNT_W'(UNROLL);
      end
      if (final_c) begin
        for (int i = 0; i < int'(NW); i++) digest_q[64*i +: 64] <= (h_q[i] + v_q[i]) & mask_c;
      end
`ifdef SHA2_ZEROIZE_EN
      if (hs_c) begin
        digest_q <= '0;
        for (int i = 0; i < int'(NW); i++) begin
          h_q[i] <= '0;
          v_q[i] <= '0;
        end
        for (int j = 0; j < int'(NM); j++) w_q[j] <= '0;
      end
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign digest_out = digest_q;

endmodule

// File: tb/tb_sha2_compress_iter.sv
// Testbench for sha2_compress_iter: known-answer vectors, handshake corner
// cases and randomized blocks checked against a plain SHA-2 reference model.
module tb_sha2_compress_iter;

  localparam int unsigned UNR = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          mode_in;
  logic [511:0]  state_in;
  logic [1023:0] block_in;
  logic          out_valid;
  logic          out_ready;
  logic [511:0]  digest_out;
  logic          busy;

  always #5 clk = ~clk;

  sha2_compress_iter #(.UNROLL(UNR)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode_in    (mode_in),
    .state_in   (state_in),
    .block_in   (block_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .digest_out (digest_out),
    .busy       (busy)
  );

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam bit [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam bit [63:0] IV512 [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
                                       64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                       64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                                       64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam bit [31:0] ABC256 [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam bit [31:0] TWO256 [8] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam bit [31:0] MSG2 [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071};

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] ror32(input bit [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic bit [63:0] ror64(input bit [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference SHA-2 compression: full 64/80-entry schedule array, textbook round loop.
  function automatic logic [511:0] ref_digest(input logic m, input logic [511:0] st,
                                              input logic [1023:0] blk);
    logic [511:0] r;
    bit [31:0] w32 [64];
    bit [31:0] a32 [8];
    bit [31:0] x1, x2;
    bit [63:0] w64 [80];
    bit [63:0] a64 [8];
    bit [63:0] y1, y2;
    r = '0;
    if (!m) begin
      for (int i = 0; i < 16; i++) w32[i] = blk[64*i +: 32];
      for (int i = 16; i < 64; i++)
        w32[i] = (ror32(w32[i-2], 17) ^ ror32(w32[i-2], 19) ^ (w32[i-2] >> 10)) + w32[i-7]
               + (ror32(w32[i-15], 7) ^ ror32(w32[i-15], 18) ^ (w32[i-15] >> 3)) + w32[i-16];
      for (int i = 0; i < 8; i++) a32[i] = st[64*i +: 32];
      for (int t = 0; t < 64; t++) begin
        x1 = a32[7] + (ror32(a32[4], 6) ^ ror32(a32[4], 11) ^ ror32(a32[4], 25))
           + ((a32[4] & a32[5]) ^ (~a32[4] & a32[6])) + K512[t][63:32] + w32[t];
        x2 = (ror32(a32[0], 2) ^ ror32(a32[0], 13) ^ ror32(a32[0], 22))
           + ((a32[0] & a32[1]) ^ (a32[0] & a32[2]) ^ (a32[1] & a32[2]));
        for (int i = 7; i > 0; i--) a32[i] = a32[i-1];
        a32[4] = a32[4] + x1;
        a32[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) r[64*i +: 64] = {32'h0, st[64*i +: 32] + a32[i]};
    end else begin
      for (int i = 0; i < 16; i++) w64[i] = blk[64*i +: 64];
      for (int i = 16; i < 80; i++)
        w64[i] = (ror64(w64[i-2], 19) ^ ror64(w64[i-2], 61) ^ (w64[i-2] >> 6)) + w64[i-7]
               + (ror64(w64[i-15], 1) ^ ror64(w64[i-15], 8) ^ (w64[i-15] >> 7)) + w64[i-16];
      for (int i = 0; i < 8; i++) a64[i] = st[64*i +: 64];
      for (int t = 0; t < 80; t++) begin
        y1 = a64[7] + (ror64(a64[4], 14) ^ ror64(a64[4], 18) ^ ror64(a64[4], 41))
           + ((a64[4] & a64[5]) ^ (~a64[4] & a64[6])) + K512[t] + w64[t];
        y2 = (ror64(a64[0], 28) ^ ror64(a64[0], 34) ^ ror64(a64[0], 39))
           + ((a64[0] & a64[1]) ^ (a64[0] & a64[2]) ^ (a64[1] & a64[2]));
        for (int i = 7; i > 0; i--) a64[i] = a64[i-1];
        a64[4] = a64[4] + y1;
        a64[0] = y1 + y2;
      end
      for (int i = 0; i < 8; i++) r[64*i +: 64] = st[64*i +: 64] + a64[i];
    end
    return r;
  endfunction

  function automatic logic [1023:0] rand_bits1024();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [511:0] rand_bits512();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // One full transaction: accept, latency, digest, optional backpressure, handshake.
  task automatic run_txn(input logic m, input logic [511:0] st, input logic [1023:0] blk,
                         input int hold, input logic poke, output logic [511:0] dig);
    logic [511:0] exp_d;
    int           cyc;
    int           exp_lat;
    exp_d   = ref_digest(m, st, blk);
    exp_lat = (m ? 80 : 64) / int'(UNR) + 2;
    dig     = '0;
    cyc     = 0;
    while (!in_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("ready_before_accept", 512'(in_ready), 512'(1'b1));
    mode_in  = m;
    state_in = st;
    block_in = blk;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode_in  = ~m;
    state_in = rand_bits512();
    block_in = rand_bits1024();
    check_eq("busy_after_accept", 512'({busy, in_ready}), 512'(2'b10));
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", 512'(cyc), 512'(exp_lat));
    if (!out_valid) return;
    check_eq("digest", digest_out, exp_d);
    dig = digest_out;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        mode_in  = 1'($urandom);
        state_in = rand_bits512();
        block_in = rand_bits1024();
      end
      @(posedge clk); #1;
      check_eq("bp_digest_stable", digest_out, exp_d);
      check_eq("bp_flags", 512'({out_valid, in_ready, busy}), 512'(3'b101));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("post_hs_flags", 512'({out_valid, in_ready, busy}), 512'(3'b010));
`ifdef SHA2_ZEROIZE_EN
    check_eq("idle_digest", digest_out, 512'(0));
`else
    check_eq("idle_digest", digest_out, exp_d);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0]  iv256, iv512, kat, d, d1;
    logic [1023:0] abc256, abc512, blk1, blk2;
    logic          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode_in = 1'b0;
    state_in = '0; block_in = '0;

    iv256 = '0; iv512 = '0; abc256 = '0; abc512 = '0; blk1 = '0; blk2 = '0;
    for (int i = 0; i < 8; i++) begin
      iv256[64*i +: 64] = {32'h0, IV256[i]};
      iv512[64*i +: 64] = IV512[i];
    end
    abc256[31:0]          = 32'h61626380;
    abc256[64*15 +: 64]   = 64'h18;
    abc512[63:0]          = 64'h6162638000000000;
    abc512[64*15 +: 64]   = 64'h18;
    for (int i = 0; i < 14; i++) blk1[64*i +: 64] = {32'h0, MSG2[i]};
    blk1[64*14 +: 64]     = 64'h80000000;
    blk2[64*15 +: 64]     = 64'h1c0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_flags", 512'({in_ready, out_valid, busy}), 512'(3'b100));
    check_eq("reset_digest", digest_out, 512'(0));

    // SHA-256 "abc" known answer
    run_txn(1'b0, iv256, abc256, 0, 1'b0, d);
    kat = '0;
    for (int i = 0; i < 8; i++) kat[64*i +: 64] = {32'h0, ABC256[i]};
    check_eq("kat_sha256_abc", d, kat);

    // SHA-512 "abc" known answer (first and last lanes)
    run_txn(1'b1, iv512, abc512, 0, 1'b0, d);
    check_eq("kat_sha512_h0", 512'(d[63:0]), 512'(64'hddaf35a193617aba));
    check_eq("kat_sha512_h7", 512'(d[64*7 +: 32]), 512'(32'ha54ca49f));

    // Backpressure with ignored in_valid pulses
    run_txn(1'b0, iv256, abc256, 10, 1'b1, d);
    check_eq("bp_kat", d, kat);

    // Abort mid-run with reset
    mode_in = 1'b0; state_in = iv256; block_in = abc256; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_flags", 512'({in_ready, out_valid, busy}), 512'(3'b100));
    check_eq("abort_digest", digest_out, 512'(0));
    seen = 1'b0;
    repeat (90) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("abort_no_out", 512'(seen), 512'(1'b0));
    run_txn(1'b0, iv256, abc256, 0, 1'b0, d);
    check_eq("after_abort_kat", d, kat);

    // Two chained SHA-256 blocks
    run_txn(1'b0, iv256, blk1, 1, 1'b0, d1);
    run_txn(1'b0, d1, blk2, 2, 1'b0, d);
    kat = '0;
    for (int i = 0; i < 8; i++) kat[64*i +: 64] = {32'h0, TWO256[i]};
    check_eq("kat_two_block", d, kat);

    // Randomized blocks and states in both modes
    for (int k = 0; k < 8; k++) begin
      run_txn(1'($urandom_range(0, 1)), rand_bits512(), rand_bits1024(),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
